// File: rtl/p_encoder_8_pkg.sv
// Shared constants and priority-index helper for the 8:3 priority encoder.
// The helper returns the index of the highest set bit (0 when none are set).
// Callers must qualify the index with a separate valid flag.
package p_encoder_8_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  // Scan upward so the highest set bit is the last one to overwrite idx.
  function automatic logic [OUT_W-1:0] prio_idx(input logic [IN_W-1:0] vec);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/p_encoder_8_core.sv
// Purpose: pure combinational 8:3 priority encoder. Bit 7 has the highest priority.
// Latency: zero; the outputs settle in the same timestep as in_i.
// Backpressure: none; this block has no handshake and no state.
// Ports: in_i request vector; out_o winning index; valid_o set when in_i != 0;
//        onehot_o winning-bit mask (only with P_ENCODER_8_ONEHOT_EN defined).
module p_encoder_8_core
  import p_encoder_8_pkg::*;
(
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             valid_o
`ifdef P_ENCODER_8_ONEHOT_EN
  ,
  output logic [IN_W-1:0]  onehot_o
`endif
);

  always_comb begin
    out_o   = prio_idx(in_i);
    valid_o = |in_i;
  end

`ifdef P_ENCODER_8_ONEHOT_EN
  // The index is 0 for both "bit 0 wins" and "nothing set", so the mask
  // is gated by valid to keep the empty case all-zero.
  always_comb begin
    onehot_o = '0;
    if (valid_o) onehot_o = IN_W'(1) << out_o;
  end
`endif

endmodule

// File: rtl/p_encoder_8.sv
// Purpose: 8:3 priority encoder with combinational and registered result copies.
// Latency: out/valid are combinational; out_q/valid_q arrive 1 clk later.
// Backpressure: none; the registers load on every rising clk edge.
// Ports: clk, rst_n (async active-low, clears registered outputs only);
//        in request vector; out/valid combinational; out_q/valid_q registered.
// Optional: P_ENCODER_8_ONEHOT_EN adds out_onehot and out_onehot_q.
module p_encoder_8 #(
  parameter int IN_W  = p_encoder_8_pkg::IN_W,
  parameter int OUT_W = p_encoder_8_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic [OUT_W-1:0] out_q,
  output logic             valid_q
`ifdef P_ENCODER_8_ONEHOT_EN
  ,
  output logic [IN_W-1:0]  out_onehot,
  output logic [IN_W-1:0]  out_onehot_q
`endif
);

  // The core is hard-wired for 8 inputs; refuse any other configuration.
  if (IN_W != 8) begin : g_bad_in_w
    $error("p_encoder_8: IN_W must be 8");
  end
  if (OUT_W != 3) begin : g_bad_out_w
    $error("p_encoder_8: OUT_W must be 3");
  end

  p_encoder_8_core u_core (
    .in_i     (in),
    .out_o    (out),
    .valid_o  (valid)
`ifdef P_ENCODER_8_ONEHOT_EN
    ,
    .onehot_o (out_onehot)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out;
      valid_q <= valid;
    end
  end

`ifdef P_ENCODER_8_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot_q <= '0;
    end else begin
      out_onehot_q <= out_onehot;
    end
  end
`endif

endmodule

// File: tb/tb_p_encoder_8.sv
// Directed testbench for p_encoder_8: combinational sweep, index-0 corner
// cases, registered path latency and asynchronous reset behaviour.
`timescale 1ns/100ps
module tb_p_encoder_8;
  import p_encoder_8_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
  logic [2:0] out_q;
  logic       valid_q;
`ifdef P_ENCODER_8_ONEHOT_EN
  logic [7:0] out_onehot;
  logic [7:0] out_onehot_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  p_encoder_8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .out     (out),
    .valid   (valid),
    .out_q   (out_q),
    .valid_q (valid_q)
`ifdef P_ENCODER_8_ONEHOT_EN
    ,
    .out_onehot   (out_onehot),
    .out_onehot_q (out_onehot_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (in=%h)", tag, obs, exp, in);
    end
  endtask

  // Independent downward-scan model of the priority rule.
  function automatic logic [2:0] ref_idx(input logic [7:0] v);
    logic [2:0] r;
    logic       found;
    r = 3'd0;
    found = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (!found && v[b]) begin
        r = 3'(b);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    in    = 8'h00;
    #1;
    chk("reset_out_q",   {5'b0, out_q},   8'h00);
    chk("reset_valid_q", {7'b0, valid_q}, 8'h00);
`ifdef P_ENCODER_8_ONEHOT_EN
    chk("reset_onehot_q", out_onehot_q, 8'h00);
`endif

    // Exhaustive combinational sweep.
    for (int i = 0; i < 256; i++) begin
      in = 8'(i);
      #1;
      chk("sweep_out",   {5'b0, out},   {5'b0, ref_idx(in)});
      chk("sweep_valid", {7'b0, valid}, {7'b0, (in != 8'h00)});
      chk("pkg_prio_idx", {5'b0, prio_idx(in)}, {5'b0, ref_idx(in)});
`ifdef P_ENCODER_8_ONEHOT_EN
      chk("sweep_onehot", out_onehot, (in == 8'h00) ? 8'h00 : (8'h01 << ref_idx(in)));
`endif
    end

    // Hand-computed directed vectors.
    in = 8'h00; #1;
    chk("h00_out", {5'b0, out}, 8'h00); chk("h00_valid", {7'b0, valid}, 8'h00);
    in = 8'h01; #1;
    chk("h01_out", {5'b0, out}, 8'h00); chk("h01_valid", {7'b0, valid}, 8'h01);
    in = 8'hFF; #1;
    chk("hFF_out", {5'b0, out}, 8'h07); chk("hFF_valid", {7'b0, valid}, 8'h01);
    in = 8'h80; #1;
    chk("h80_out", {5'b0, out}, 8'h07); chk("h80_valid", {7'b0, valid}, 8'h01);
    in = 8'h7F; #1;
    chk("h7F_out", {5'b0, out}, 8'h06); chk("h7F_valid", {7'b0, valid}, 8'h01);
    in = 8'b0001_0110; #1;
    chk("h16_out", {5'b0, out}, 8'h04); chk("h16_valid", {7'b0, valid}, 8'h01);
`ifdef P_ENCODER_8_ONEHOT_EN
    in = 8'b0000_1010; #1;
    chk("onehot_0A", out_onehot, 8'b0000_1000);
    in = 8'b0110_0100; #1;
    chk("onehot_64", out_onehot, 8'b0100_0000);
    in = 8'h00; #1;
    chk("onehot_00", out_onehot, 8'h00);
`endif

    // Registered path: one-cycle latency, hold between edges.
    @(negedge clk);
    rst_n = 1'b1;
    in    = 8'h20;
    #1;
    chk("pre_edge_out_q", {5'b0, out_q}, 8'h00);
    @(posedge clk); #1;
    chk("reg_h20_out_q",   {5'b0, out_q},   8'h05);
    chk("reg_h20_valid_q", {7'b0, valid_q}, 8'h01);
`ifdef P_ENCODER_8_ONEHOT_EN
    chk("reg_h20_onehot_q", out_onehot_q, 8'h20);
`endif
    in = 8'h00; #1;
    chk("hold_out_q",   {5'b0, out_q},   8'h05);
    chk("hold_valid_q", {7'b0, valid_q}, 8'h01);
    chk("hold_comb_valid", {7'b0, valid}, 8'h00);
    @(posedge clk); #1;
    chk("reg_h00_out_q",   {5'b0, out_q},   8'h00);
    chk("reg_h00_valid_q", {7'b0, valid_q}, 8'h00);

    // Asynchronous reset between edges.
    in = 8'hFF;
    @(posedge clk); #1;
    chk("reg_hFF_out_q",   {5'b0, out_q},   8'h07);
    chk("reg_hFF_valid_q", {7'b0, valid_q}, 8'h01);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_q",    {5'b0, out_q},   8'h00);
    chk("arst_valid_q",  {7'b0, valid_q}, 8'h00);
    chk("arst_out",      {5'b0, out},     8'h07);
    chk("arst_valid",    {7'b0, valid},   8'h01);
`ifdef P_ENCODER_8_ONEHOT_EN
    chk("arst_onehot_q", out_onehot_q, 8'h00);
`endif
    in = 8'h10; #1;
    chk("arst_track_out", {5'b0, out}, 8'h04);
    @(posedge clk); #1;
    chk("arst_edge_out_q",   {5'b0, out_q},   8'h00);
    chk("arst_edge_valid_q", {7'b0, valid_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge_valid_q", {7'b0, valid_q}, 8'h00);
    @(posedge clk); #1;
    chk("reload_out_q",   {5'b0, out_q},   8'h04);
    chk("reload_valid_q", {7'b0, valid_q}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
